// File: rtl/age_iq_buffer_if.sv
// Purpose: dispatch / wakeup / issue / flush bundle between the rename stage, age_iq_buffer and age_schedule.
// Latency: wires only.
// Backpressure: o_enq_rdy gates all dispatch ports together; issue, wakeup and flush are never stalled.
// Ports: master = dispatch/scheduler side (drives i_*), slave = age_iq_buffer (drives o_*).
interface age_iq_buffer_if #(
  parameter int WIDTH  = 6,
  parameter int INPUTS = 2,
  parameter int OUTS   = 2,
  parameter int ROB_W  = 6
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [INPUTS-1:0]             i_enq_vld;
  logic [INPUTS-1:0][ROB_W-1:0]  i_enq_rob;
  logic [INPUTS-1:0]             i_enq_ready;
  logic                          o_enq_rdy;
  logic                          i_wake_vld;
  logic [IDX_W-1:0]              i_wake_idx;
  logic [OUTS-1:0]               i_issue_vld;
  logic [OUTS-1:0][IDX_W-1:0]    i_issue_idx;
  logic                          i_flush;
  logic [ROB_W-1:0]              i_flush_rob;
  logic [WIDTH-1:0]              o_vld;
  logic [WIDTH-1:0][ROB_W-1:0]   o_ages;
  logic [CNT_W-1:0]              o_count;
  logic                          o_empty;

  modport master (
    output i_enq_vld, i_enq_rob, i_enq_ready, i_wake_vld, i_wake_idx,
           i_issue_vld, i_issue_idx, i_flush, i_flush_rob,
    input  o_enq_rdy, o_vld, o_ages, o_count, o_empty
  );

  modport slave (
    input  i_enq_vld, i_enq_rob, i_enq_ready, i_wake_vld, i_wake_idx,
           i_issue_vld, i_issue_idx, i_flush, i_flush_rob,
    output o_enq_rdy, o_vld, o_ages, o_count, o_empty
  );
endinterface

// File: rtl/age_iq_buffer.sv
// Purpose: issue-queue entry store; packs dispatched uops into free slots, tracks readiness, frees on issue/flush.
// Latency: 1 cycle from dispatch/wakeup/issue/flush to o_vld, o_ages, o_count.
// Backpressure: o_enq_rdy (registered state only) drops to 0 unless INPUTS slots are free; then no port is written.
// Ports: clk, rst (async, active-high), bus (age_iq_buffer_if.slave).
// Build option: define AGE_IQ_PARTIAL_FLUSH_EN to squash only entries younger than i_flush_rob;
// without it a flush clears every slot and i_flush_rob is ignored.
module age_iq_buffer #(
  parameter int WIDTH  = 6,
  parameter int INPUTS = 2,
  parameter int OUTS   = 2,
  parameter int ROB_W  = 6
) (
  input  logic            clk,
  input  logic            rst,
  age_iq_buffer_if.slave  bus
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef struct packed {
    logic             flipped;
    logic [ROB_W-2:0] idx;
  } rob_idx_t;

  logic [WIDTH-1:0]            used_q, rdy_q, used_d, rdy_d;
  logic [WIDTH-1:0][ROB_W-1:0] age_q, age_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic                        enq_rdy;

  logic [WIDTH-1:0]            issue_clr, wake_set, squash;
  logic [WIDTH-1:0]            avail, slot_wr, slot_ready;
  logic [WIDTH-1:0][ROB_W-1:0] slot_rob;
  logic [INPUTS-1:0]           placed;

`ifdef AGE_IQ_PARTIAL_FLUSH_EN
  // Wrap-aware compare: the flipped bit toggles each time the ROB index wraps.
  function automatic logic younger(input rob_idx_t a, input rob_idx_t b);
    if (a.flipped == b.flipped) return a.idx > b.idx;
    else                        return a.idx < b.idx;
  endfunction
`else
  logic unused_flush_rob;
  assign unused_flush_rob = ^bus.i_flush_rob;
`endif

  // All-or-nothing admission from registered occupancy, so it never depends on same-cycle frees.
  assign enq_rdy = (int'(count_q) + INPUTS) <= WIDTH;

  always_comb begin
    issue_clr = '0;
    wake_set  = '0;
    squash    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < OUTS; j++) begin
        if (bus.i_issue_vld[j] && bus.i_issue_idx[j] == IDX_W'(i)) issue_clr[i] = 1'b1;
      end
      if (bus.i_wake_vld && bus.i_wake_idx == IDX_W'(i)) wake_set[i] = 1'b1;
`ifdef AGE_IQ_PARTIAL_FLUSH_EN
      squash[i] = bus.i_flush && younger(rob_idx_t'(age_q[i]), rob_idx_t'(bus.i_flush_rob));
`else
      squash[i] = bus.i_flush;
`endif
    end
  end

  // Port k takes the k-th lowest free slot; avail shrinks as earlier ports claim slots.
  always_comb begin
    avail      = ~used_q;
    placed     = '0;
    slot_wr    = '0;
    slot_ready = '0;
    slot_rob   = '0;
    for (int k = 0; k < INPUTS; k++) begin
      if (bus.i_enq_vld[k] && enq_rdy && !bus.i_flush) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (!placed[k] && avail[i]) begin
            placed[k]     = 1'b1;
            avail[i]      = 1'b0;
            slot_wr[i]    = 1'b1;
            slot_rob[i]   = bus.i_enq_rob[k];
            slot_ready[i] = bus.i_enq_ready[k];
          end
        end
      end
    end
  end

  // Enqueue only targets unused slots, so it cannot collide with issue, wakeup or squash.
  always_comb begin
    used_d  = (used_q & ~issue_clr & ~squash) | slot_wr;
    rdy_d   = ((rdy_q | wake_set) & used_q & ~issue_clr & ~squash) | (slot_wr & slot_ready);
    count_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      age_d[i] = slot_wr[i] ? slot_rob[i] : age_q[i];
      count_d  = count_d + CNT_W'(used_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      used_q  <= '0;
      rdy_q   <= '0;
      age_q   <= '0;
      count_q <= '0;
    end else begin
      used_q  <= used_d;
      rdy_q   <= rdy_d;
      age_q   <= age_d;
      count_q <= count_d;
    end
  end

  assign bus.o_vld     = used_q & rdy_q;
  assign bus.o_ages    = age_q;
  assign bus.o_count   = count_q;
  assign bus.o_empty   = (count_q == '0);
  assign bus.o_enq_rdy = enq_rdy;
endmodule
